count_mod_n: RTL and testbench
==============================

# count_mod_n

Parametrised, cascadable modulo-N digit counter for the watch time-keeping chain. It generalises the fixed 0–9 minute counter to any modulus and width, for seconds, minutes, hours and 12/24 h digits. Additions over that counter:
- single clock domain with a tick enable, instead of a ripple clock per stage
- up/down counting for time setting
- synchronous load, with detection of illegal load values
- one-cycle carry/borrow pulse that drives the next stage's tick

## Interface
Parameters:
- MOD, 10, counter modulus; count range 0..MOD-1; MOD >= 2
- WIDTH, 4, count width; WIDTH >= clog2(MOD)
- RST_VAL, 0, count value after reset; RST_VAL < MOD

Ports:
- clk_i  input  1  system clock; single clock for the whole block
- rst_i  input  1  reset, synchronous, active-high
- tick_i  input  1  count enable; one-cycle pulse, sampled on rising clk_i
- dir_i  input  1  0 = count up, 1 = count down; sampled with tick_i
- hold_i  input  1  1 = ignore tick_i (freeze count during time set)
- load_i  input  1  load strobe, one cycle
- lval_i  input  WIDTH  load value, sampled when load_i = 1
- count_o  output  WIDTH  current count, fully encoded (external 7-segment decode)
- carry_o  output  1  registered one-cycle carry/borrow pulse
- toggle_o  output  1  divided-clock output; flips on every carry/borrow event
- lerr_o  output  1  sticky illegal-load flag

## Operation
- Priority per cycle: rst_i > load_i > (tick_i & !hold_i) > idle.
- Reset (rst_i = 1): count_o = RST_VAL, carry_o = 0, toggle_o = 0, lerr_o = 0. Reset mid-count aborts any pending carry.
- Valid load (load_i = 1, lval_i < MOD):
  - count_o <= lval_i, lerr_o <= 0, carry_o <= 0.
  - toggle_o unchanged; tick_i in the same cycle is dropped.
- Illegal load (load_i = 1, lval_i >= MOD):
  - count_o unchanged, lerr_o <= 1, carry_o <= 0.
  - Tick in the same cycle is dropped.
- Up tick (dir_i = 0):
  - count < MOD-1: count + 1, carry_o <= 0.
  - count == MOD-1: count <= 0, carry_o <= 1, toggle_o flips.
- Down tick (dir_i = 1):
  - count > 0: count - 1, carry_o <= 0.
  - count == 0: count <= MOD-1, carry_o <= 1 (borrow), toggle_o flips.
- Idle, hold_i = 1, or tick_i = 0: count_o, toggle_o and lerr_o hold; carry_o <= 0.
- Arithmetic: next-value comparisons are made against MOD-1 and 0 only, so the count never exceeds MOD-1 and WIDTH never overflows. Unused encodings are unreachable except through a fault.
- Cascading: stage k tick_i = stage k-1 carry_o; all stages share clk_i and dir_i.

## Timing
- All outputs are registered; no combinational path from input to output.
- Latency: tick_i sampled at edge n → count_o and carry_o updated after edge n. carry_o is high for exactly the one cycle in which count_o shows the wrapped value.
- Cascade skew: each stage updates one cycle after its predecessor wraps. A chain of k stages settles k cycles after the source tick, so consecutive ticks must be spaced at least k+1 cycles apart.
- Back-to-back ticks: with the counter at MOD-1, ticks on consecutive cycles give carry_o = 1 then 0; no pulse is stretched or merged.
- Load: count_o equals lval_i the cycle after load_i; lerr_o updates on the same edge.
- toggle_o period = 2·MOD tick periods under steady counting.

## Configuration
- COUNT_MOD_N_TOGGLE_EN defined: toggle_o register and flip logic are present, as described above.
- COUNT_MOD_N_TOGGLE_EN not defined: toggle_o is tied to 0 and no toggle register is synthesised. All other behaviour is identical.

## Test plan
- MOD = 10, reset then 10 up-ticks → count_o 0,1,…,9,0; carry_o = 1 only in the cycle count_o returns to 0; toggle_o 0→1 (macro on).
- MOD = 6, count = 0, dir_i = 1, one tick → count_o = 5, carry_o = 1 for one cycle; second tick → 4, carry_o = 0.
- MOD = 10, count = 9, load_i = 1 with lval_i = 3 and tick_i = 1 in the same cycle → count_o = 3, carry_o = 0, toggle_o unchanged.
- MOD = 10, load lval_i = 12 → count_o unchanged, lerr_o = 1 and stays 1 through ticks; then load lval_i = 4 → count_o = 4, lerr_o = 0.
- Two stages, MOD 10 then MOD 6, source count 59, one up-tick → stage 0 = 0 after 1 cycle, stage 1 = 0 after 2 cycles; with hold_i = 1 the count stays at 59.
- rst_i asserted mid-count at count 7, RST_VAL = 2 → next cycle count_o = 2, carry_o = 0, toggle_o = 0, lerr_o = 0; with the macro off, toggle_o = 0 throughout.

Source files
------------

// File: rtl/count_mod_n.sv
// Cascadable modulo-MOD digit counter with tick enable, up/down, load and carry output.
// Optional divided-clock output toggle_o is built only when COUNT_MOD_N_TOGGLE_EN is defined.
module count_mod_n #(
  parameter int MOD     = 10,
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             dir_i,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] lval_i,
  output logic [WIDTH-1:0] count_o,
  output logic             carry_o,
  output logic             toggle_o,
  output logic             lerr_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;
  logic             lerr_nxt;
  logic             load_legal;

  // Widened so the legality test holds even when MOD is a power of two.
  assign load_legal = (32'(lval_i) < 32'(MOD));

  always_comb begin
    count_nxt = count_o;
    carry_nxt = 1'b0;
    lerr_nxt  = lerr_o;
    if (load_i) begin
      if (load_legal) begin
        count_nxt = lval_i;
        lerr_nxt  = 1'b0;
      end else begin
        lerr_nxt  = 1'b1;
      end
    end else if (tick_i && !hold_i) begin
      if (!dir_i) begin
        if (count_o == MAX_VAL) begin
          count_nxt = '0;
          carry_nxt = 1'b1;
        end else begin
          count_nxt = count_o + WIDTH'(1);
        end
      end else begin
        if (count_o == '0) begin
          count_nxt = MAX_VAL;
          carry_nxt = 1'b1;
        end else begin
          count_nxt = count_o - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= RST_CNT;
      carry_o <= 1'b0;
      lerr_o  <= 1'b0;
    end else begin
      count_o <= count_nxt;
      carry_o <= carry_nxt;
      lerr_o  <= lerr_nxt;
    end
  end

`ifdef COUNT_MOD_N_TOGGLE_EN
  // A wrap in either direction is exactly when a carry/borrow is issued.
  logic toggle_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      toggle_q <= 1'b0;
    end else if (carry_nxt) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign toggle_o = toggle_q;
`else
  assign toggle_o = 1'b0;
`endif

endmodule

// File: tb/tb_count_mod_n.sv
// Directed self-checking bench for count_mod_n: single stages, a two-stage cascade and reset behaviour.
module tb_count_mod_n;

`ifdef COUNT_MOD_N_TOGGLE_EN
  localparam int TOG = 1;
`else
  localparam int TOG = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stage A: MOD 10, reset value 0
  logic       aRst, aTick, aDir, aHold, aLoad;
  logic [3:0] aLval, aCount;
  logic       aCarry, aToggle, aLerr;

  // Stage B: MOD 6, down counting
  logic       bRst, bTick, bDir, bHold, bLoad;
  logic [2:0] bLval, bCount;
  logic       bCarry, bToggle, bLerr;

  // Cascade: MOD 10 feeding MOD 6
  logic       cRst, cTick, cDir, cHold, cLoad;
  logic [3:0] c0Lval, c0Count;
  logic [2:0] c1Lval, c1Count;
  logic       c0Carry, c0Toggle, c0Lerr, c1Carry, c1Toggle, c1Lerr;

  // Stage R: MOD 10, reset value 2
  logic       rRst, rTick, rDir, rHold, rLoad;
  logic [3:0] rLval, rCount;
  logic       rCarry, rToggle, rLerr;

  count_mod_n #(.MOD(10), .WIDTH(4), .RST_VAL(0)) dutA (
    .clk_i(clk), .rst_i(aRst), .tick_i(aTick), .dir_i(aDir), .hold_i(aHold),
    .load_i(aLoad), .lval_i(aLval), .count_o(aCount), .carry_o(aCarry),
    .toggle_o(aToggle), .lerr_o(aLerr));

  count_mod_n #(.MOD(6), .WIDTH(3), .RST_VAL(0)) dutB (
    .clk_i(clk), .rst_i(bRst), .tick_i(bTick), .dir_i(bDir), .hold_i(bHold),
    .load_i(bLoad), .lval_i(bLval), .count_o(bCount), .carry_o(bCarry),
    .toggle_o(bToggle), .lerr_o(bLerr));

  count_mod_n #(.MOD(10), .WIDTH(4), .RST_VAL(0)) dutC0 (
    .clk_i(clk), .rst_i(cRst), .tick_i(cTick), .dir_i(cDir), .hold_i(cHold),
    .load_i(cLoad), .lval_i(c0Lval), .count_o(c0Count), .carry_o(c0Carry),
    .toggle_o(c0Toggle), .lerr_o(c0Lerr));

  count_mod_n #(.MOD(6), .WIDTH(3), .RST_VAL(0)) dutC1 (
    .clk_i(clk), .rst_i(cRst), .tick_i(c0Carry), .dir_i(cDir), .hold_i(cHold),
    .load_i(cLoad), .lval_i(c1Lval), .count_o(c1Count), .carry_o(c1Carry),
    .toggle_o(c1Toggle), .lerr_o(c1Lerr));

  count_mod_n #(.MOD(10), .WIDTH(4), .RST_VAL(2)) dutR (
    .clk_i(clk), .rst_i(rRst), .tick_i(rTick), .dir_i(rDir), .hold_i(rHold),
    .load_i(rLoad), .lval_i(rLval), .count_o(rCount), .carry_o(rCarry),
    .toggle_o(rToggle), .lerr_o(rLerr));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    aRst = 1; aTick = 0; aDir = 0; aHold = 0; aLoad = 0; aLval = '0;
    bRst = 1; bTick = 0; bDir = 0; bHold = 0; bLoad = 0; bLval = '0;
    cRst = 1; cTick = 0; cDir = 0; cHold = 0; cLoad = 0; c0Lval = '0; c1Lval = '0;
    rRst = 1; rTick = 0; rDir = 0; rHold = 0; rLoad = 0; rLval = '0;
    applyStimulus();
    applyStimulus();
    aRst = 0; bRst = 0; cRst = 0; rRst = 0;

    $display("[TB] reset state");
    checkOutput("a_rst_count", int'(aCount), 0);
    checkOutput("a_rst_carry", int'(aCarry), 0);
    checkOutput("a_rst_toggle", int'(aToggle), 0);
    checkOutput("a_rst_lerr", int'(aLerr), 0);
    checkOutput("r_rst_count", int'(rCount), 2);

    $display("[TB] ten up ticks on MOD 10");
    aTick = 1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus();
      checkOutput($sformatf("a_up_count%0d", i), int'(aCount), i % 10);
      checkOutput($sformatf("a_up_carry%0d", i), int'(aCarry), (i == 10) ? 1 : 0);
      checkOutput($sformatf("a_up_toggle%0d", i), int'(aToggle), (i == 10) ? TOG : 0);
    end
    applyStimulus();
    checkOutput("a_b2b_count", int'(aCount), 1);
    checkOutput("a_b2b_carry", int'(aCarry), 0);
    aTick = 0;
    applyStimulus();
    checkOutput("a_idle_count", int'(aCount), 1);
    checkOutput("a_idle_toggle", int'(aToggle), TOG);

    $display("[TB] load has priority over tick");
    aLoad = 1; aLval = 4'd9;
    applyStimulus();
    checkOutput("a_load9_count", int'(aCount), 9);
    aLval = 4'd3; aTick = 1;
    applyStimulus();
    checkOutput("a_loadtick_count", int'(aCount), 3);
    checkOutput("a_loadtick_carry", int'(aCarry), 0);
    checkOutput("a_loadtick_toggle", int'(aToggle), TOG);

    $display("[TB] illegal loads");
    aTick = 0; aLval = 4'd12;
    applyStimulus();
    checkOutput("a_bad12_count", int'(aCount), 3);
    checkOutput("a_bad12_lerr", int'(aLerr), 1);
    aLoad = 0; aTick = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("a_sticky_count", int'(aCount), 5);
    checkOutput("a_sticky_lerr", int'(aLerr), 1);
    aTick = 0; aLoad = 1; aLval = 4'd4;
    applyStimulus();
    checkOutput("a_load4_count", int'(aCount), 4);
    checkOutput("a_load4_lerr", int'(aLerr), 0);
    aLval = 4'd10;
    applyStimulus();
    checkOutput("a_bad10_count", int'(aCount), 4);
    checkOutput("a_bad10_lerr", int'(aLerr), 1);
    aLval = 4'd9;
    applyStimulus();
    checkOutput("a_load9b_lerr", int'(aLerr), 0);
    aLoad = 0; aHold = 1; aTick = 1;
    applyStimulus();
    checkOutput("a_hold_count", int'(aCount), 9);
    checkOutput("a_hold_carry", int'(aCarry), 0);
    aHold = 0; aTick = 0;

    $display("[TB] down count on MOD 6");
    bDir = 1; bTick = 1;
    applyStimulus();
    checkOutput("b_borrow_count", int'(bCount), 5);
    checkOutput("b_borrow_carry", int'(bCarry), 1);
    checkOutput("b_borrow_toggle", int'(bToggle), TOG);
    applyStimulus();
    checkOutput("b_down_count", int'(bCount), 4);
    checkOutput("b_down_carry", int'(bCarry), 0);
    bTick = 0;

    $display("[TB] two-stage cascade 59 -> 00");
    cLoad = 1; c0Lval = 4'd9; c1Lval = 3'd5;
    applyStimulus();
    checkOutput("c_load_c0", int'(c0Count), 9);
    checkOutput("c_load_c1", int'(c1Count), 5);
    cLoad = 0; cTick = 1;
    applyStimulus();
    cTick = 0;
    checkOutput("c_cyc1_c0", int'(c0Count), 0);
    checkOutput("c_cyc1_c0carry", int'(c0Carry), 1);
    checkOutput("c_cyc1_c1", int'(c1Count), 5);
    applyStimulus();
    checkOutput("c_cyc2_c1", int'(c1Count), 0);
    checkOutput("c_cyc2_c1carry", int'(c1Carry), 1);
    checkOutput("c_cyc2_c0carry", int'(c0Carry), 0);
    applyStimulus();
    checkOutput("c_cyc3_c1carry", int'(c1Carry), 0);
    cLoad = 1;
    applyStimulus();
    cLoad = 0; cHold = 1; cTick = 1;
    applyStimulus();
    cTick = 0;
    applyStimulus();
    checkOutput("c_hold_c0", int'(c0Count), 9);
    checkOutput("c_hold_c1", int'(c1Count), 5);
    checkOutput("c_hold_c1carry", int'(c1Carry), 0);
    cHold = 0;

    $display("[TB] reset mid-count with RST_VAL 2");
    rLoad = 1; rLval = 4'd15;
    applyStimulus();
    checkOutput("r_bad_lerr", int'(rLerr), 1);
    rLoad = 0; rTick = 1;
    for (int i = 0; i < 15; i++) applyStimulus();
    checkOutput("r_mid_count", int'(rCount), 7);
    checkOutput("r_mid_toggle", int'(rToggle), TOG);
    checkOutput("r_mid_lerr", int'(rLerr), 1);
    rRst = 1;
    applyStimulus();
    checkOutput("r_rst7_count", int'(rCount), 2);
    checkOutput("r_rst7_carry", int'(rCarry), 0);
    checkOutput("r_rst7_toggle", int'(rToggle), 0);
    checkOutput("r_rst7_lerr", int'(rLerr), 0);
    rRst = 0;
    for (int i = 0; i < 7; i++) applyStimulus();
    checkOutput("r_at9_count", int'(rCount), 9);
    rRst = 1;
    applyStimulus();
    checkOutput("r_rst9_count", int'(rCount), 2);
    checkOutput("r_rst9_carry", int'(rCarry), 0);
    rRst = 0; rTick = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
